pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter WIDTH, default 3: stimulus vector width; legal range 1..8.
REQ-002 Parameter HOLD, default 20: clock cycles each vector is held; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 mode  input  2  sweep order: 0 binary up, 1 Gray up, 2 walking-one, 3 binary down; latched on accepted start.
REQ-007 abort  input  1  terminate sweep immediately.
REQ-008 y  input  1  DUT response to the current vector.
REQ-009 x  output  WIDTH  stimulus vector driven to DUT.
REQ-010 vec_idx  output  WIDTH  ordinal of current vector within the sweep.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  one-cycle pulse on sweep completion.
REQ-013 ones_cnt  output  WIDTH+1  count of sampled y==1 in the last completed or current sweep.
REQ-014 resp_map  output  2**WIDTH  captured truth table; bit k = y sampled while x==k.

Function
REQ-015 States: IDLE, RUN, DONE.
REQ-016 IDLE: start=1 latches mode, clears ones_cnt and resp_map, sets vec_idx=0, hold counter=0, enters RUN next cycle.
REQ-017 x = f(mode, vec_idx) registered: binary up x=idx; Gray x=idx^(idx>>1); walking-one x=1<<idx; binary down x=(2**WIDTH-1)-idx.
REQ-018 Vector count N = 2**WIDTH for modes 0,1,3; N = WIDTH for mode 2.
REQ-019 In RUN each vector is held exactly HOLD cycles; hold counter counts 0..HOLD-1.
REQ-020 On the cycle hold counter == HOLD-1, y is sampled: resp_map[x] <= y, ones_cnt increments if y==1.
REQ-021 Same cycle, if vec_idx < N-1 then vec_idx increments and hold counter clears; else transition to DONE.
REQ-022 DONE lasts one cycle with done=1, busy=0, then IDLE; x, ones_cnt, resp_map hold their final values in IDLE.
REQ-023 start while in RUN or DONE is ignored; mode changes during RUN have no effect.
REQ-024 abort=1 in RUN: next cycle IDLE, x=0, vec_idx=0, no done pulse; ones_cnt/resp_map keep partial results; the sample scheduled that cycle is discarded.
REQ-025 abort has priority over sample/advance; abort in IDLE or DONE is ignored (DONE still returns to IDLE with done pulse already given).
REQ-026 vec_idx never wraps; ones_cnt maximum 2**WIDTH fits in WIDTH+1 bits without saturation.
REQ-027 Total sweep latency start-accept to done = N*HOLD+1 cycles.

Reset
REQ-028 rst_n low asynchronously forces IDLE, x=0, vec_idx=0, hold counter=0, busy=0, done=0, ones_cnt=0, resp_map=0, latched mode=0.
REQ-029 Reset mid-sweep discards all progress; first start after release begins a fresh sweep.

Structure
REQ-030 Shared package holds mode encodings (MODE_BIN_UP, MODE_GRAY, MODE_WALK1, MODE_BIN_DOWN) and state enum.
REQ-031 One sub-module, pattern_encode: combinational mode/idx to x mapping, WIDTH-parametrised.

Verification
REQ-032 WIDTH=3, HOLD=20, mode 0, y=^x: x steps 0..7 each 20 cycles, done at cycle 161 after start, resp_map=8'b1001_0110, ones_cnt=4.
REQ-033 WIDTH=3, HOLD=2, mode 1: x sequence 0,1,3,2,6,7,5,4; resp_map with y=x[2] equals 8'hF0.
REQ-034 WIDTH=4, HOLD=1, mode 2, y=1: x = 1,2,4,8, done after 5 cycles, ones_cnt=4, resp_map=16'h0116.
REQ-035 Mode 3, abort asserted during third vector: IDLE next cycle, x=0, no done, ones_cnt reflects two samples only.
REQ-036 rst_n pulsed low mid-sweep (not clock-aligned): all outputs zero immediately; start during RUN ignored; back-to-back sweeps restart counts.

Source files
------------

// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer: sweep-order encodings,
// controller states and the per-mode vector count.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_BIN_UP   = 2'd0,
    MODE_GRAY     = 2'd1,
    MODE_WALK1    = 2'd2,
    MODE_BIN_DOWN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Hold counter width; covers HOLD up to 65535.
  localparam int HOLD_CNT_W = 16;

  // Number of vectors in one sweep: walking-one visits each bit once,
  // every other order visits the full code space.
  function automatic int num_vectors(input mode_e m, input int width);
    return (m == MODE_WALK1) ? width : (1 << width);
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Handshake/bus bundle between a sweep controller user (master) and the
// pattern sequencer (slave).
interface pattern_sequencer_if #(
  parameter int WIDTH = 3
) ();
  logic                  start;
  logic [1:0]            mode;
  logic                  abort;
  logic                  y;
  logic [WIDTH-1:0]      x;
  logic [WIDTH-1:0]      vec_idx;
  logic                  busy;
  logic                  done;
  logic [WIDTH:0]        ones_cnt;
  logic [2**WIDTH-1:0]   resp_map;

  modport master (
    output start, mode, abort, y,
    input  x, vec_idx, busy, done, ones_cnt, resp_map
  );

  modport slave (
    input  start, mode, abort, y,
    output x, vec_idx, busy, done, ones_cnt, resp_map
  );
endinterface

// File: rtl/pattern_sequencer_encode.sv
// Combinational sweep-order mapping from vector ordinal to stimulus value.
module pattern_encode
  import pattern_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] x
);

  // Down-count uses ~idx, which equals (2**WIDTH-1)-idx.
  always_comb begin
    x = '0;
    case (mode)
      MODE_BIN_UP:   x = idx;
      MODE_GRAY:     x = idx ^ (idx >> 1);
      MODE_WALK1:    x = WIDTH'(1) << idx;
      MODE_BIN_DOWN: x = ~idx;
      default:       x = idx;
    endcase
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Stimulus sweep controller: steps a registered vector x through a
// mode-dependent order, holds each vector HOLD cycles, samples the DUT
// response on the last hold cycle and builds a truth table plus ones count.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int HOLD  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  pattern_sequencer_if.slave  bus
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD - 1);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [WIDTH-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]        x_q, x_d;
  logic [HOLD_CNT_W-1:0]   hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH:0]          ones_q, ones_d;
  logic [2**WIDTH-1:0]     map_q, map_d;

  mode_e                   enc_mode;
  logic [WIDTH-1:0]        enc_idx, enc_x;
  logic [WIDTH:0]          last_idx;

  // The encoder always looks one vector ahead: vector 0 of the requested
  // mode while idle, otherwise the successor of the current vector.
  assign enc_mode = (state_q == ST_IDLE) ? mode_e'(bus.mode) : mode_q;
  assign enc_idx  = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;
  assign last_idx = (WIDTH+1)'(num_vectors(mode_q, WIDTH) - 1);

  pattern_encode #(.WIDTH(WIDTH)) u_encode (
    .mode (enc_mode),
    .idx  (enc_idx),
    .x    (enc_x)
  );

  // Next-state: accept, hold/sample/advance, abort (wins over sampling), done.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    x_d     = x_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    map_d   = map_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = mode_e'(bus.mode);
          idx_d   = '0;
          hold_d  = '0;
          x_d     = enc_x;
          ones_d  = '0;
          map_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          // Partial results stay visible; the pending sample is dropped.
          idx_d   = '0;
          hold_d  = '0;
          x_d     = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          map_d[x_q] = bus.y;
          ones_d     = ones_q + (WIDTH+1)'(bus.y);
          if ({1'b0, idx_q} < last_idx) begin
            idx_d  = idx_q + 1'b1;
            hold_d = '0;
            x_d    = enc_x;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BIN_UP;
      idx_q   <= '0;
      x_q     <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      map_q   <= map_d;
    end
  end

  assign bus.x        = x_q;
  assign bus.vec_idx  = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ones_cnt = ones_q;
  assign bus.resp_map = map_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: three instances (W3/H2 main, W4/H1, W3/H20),
// directed sweep table, randomized sweeps against a sweep-level model,
// and hand-written reset / abort / timing sequences.
module tb_pattern_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ytab_a = 8'h00;

  pattern_sequencer_if #(.WIDTH(3)) a_if ();
  pattern_sequencer_if #(.WIDTH(4)) b_if ();
  pattern_sequencer_if #(.WIDTH(3)) c_if ();

  // DUT responses: table lookup, constant one, parity.
  assign a_if.y = ytab_a[a_if.x];
  assign b_if.y = 1'b1;
  assign c_if.y = ^c_if.x;

  pattern_sequencer #(.WIDTH(3), .HOLD(2))  u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  pattern_sequencer #(.WIDTH(4), .HOLD(1))  u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  pattern_sequencer #(.WIDTH(3), .HOLD(20)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Vector i of a sweep, straight from the ordering rules.
  function automatic int exp_x(input int mode, input int i, input int w);
    int full;
    full = (1 << w) - 1;
    case (mode)
      0:       return i;
      1:       return (i ^ (i >> 1)) & full;
      2:       return (1 << i) & full;
      default: return full - i;
    endcase
  endfunction

  // Sweep-level outcome after 'samples' vectors have been sampled.
  function automatic void model(input int mode, input logic [7:0] yt, input int samples,
                                output logic [7:0] m, output int o);
    int xv;
    m = 8'h00;
    o = 0;
    for (int i = 0; i < samples; i++) begin
      xv = exp_x(mode, i, 3);
      m[xv] = yt[xv];
      o += int'(yt[xv]);
    end
  endfunction

  // One sweep on instance A (W=3, H=2). Entered/left at posedge+1.
  // abort_vec<0: run to completion; else abort on cycle abort_off of that vector.
  task automatic run_a(input int mode, input logic [7:0] yt, input int abort_vec,
                       input int abort_off, input logic [7:0] em, input int eo);
    int n, h, abort_k;
    bit aborted;
    n = (mode == 2) ? 3 : 8;
    h = 2;
    aborted = 0;
    abort_k = (abort_vec >= 0) ? abort_vec * h + abort_off : -1;
    ytab_a = yt;
    a_if.start = 1'b1;
    a_if.mode  = 2'(mode);
    step();
    for (int k = 0; k < n * h; k++) begin
      // Mode wiggles and repeated starts during RUN must be ignored.
      a_if.mode  = 2'($urandom_range(0, 3));
      a_if.start = 1'($urandom_range(0, 1));
      chk("a_x", int'(a_if.x), exp_x(mode, k / h, 3));
      chk("a_idx", int'(a_if.vec_idx), k / h);
      chk("a_busy", int'(a_if.busy), 1);
      chk("a_done_early", int'(a_if.done), 0);
      if (k == abort_k) begin
        a_if.abort = 1'b1;
        a_if.start = 1'b0;
        step();
        a_if.abort = 1'b0;
        chk("abort_x", int'(a_if.x), 0);
        chk("abort_idx", int'(a_if.vec_idx), 0);
        chk("abort_busy", int'(a_if.busy), 0);
        chk("abort_done", int'(a_if.done), 0);
        aborted = 1;
        break;
      end
      step();
    end
    a_if.start = 1'b0;
    if (!aborted) begin
      chk("a_done", int'(a_if.done), 1);
      chk("a_busy_done", int'(a_if.busy), 0);
      chk("a_x_final", int'(a_if.x), exp_x(mode, n - 1, 3));
    end
    step();
    chk("a_done_clear", int'(a_if.done), 0);
    chk("a_map", int'(a_if.resp_map), int'(em));
    chk("a_ones", int'(a_if.ones_cnt), eo);
  endtask

  typedef struct {
    int         mode;
    logic [7:0] yt;
    int         abort_vec;
    int         abort_off;
    logic [7:0] exp_map;
    int         exp_ones;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cnt, m, n, av, ao, samples, eo;
    logic [7:0] yt, em;

    tbl[0] = '{1, 8'hF0, -1, 0, 8'hF0, 4};  // Gray, y = x[2]
    tbl[1] = '{0, 8'h96, -1, 0, 8'h96, 4};  // binary up, parity
    tbl[2] = '{2, 8'hFF, -1, 0, 8'h16, 3};  // walking-one 1,2,4
    tbl[3] = '{3, 8'hFF,  2, 1, 8'hC0, 2};  // down, abort on third vector's sample cycle
    tbl[4] = '{3, 8'h0F, -1, 0, 8'h0F, 4};  // binary down full
    tbl[5] = '{2, 8'h00, -1, 0, 8'h00, 0};  // walking-one, all zero
    tbl[6] = '{0, 8'h5A,  0, 0, 8'h00, 0};  // abort on first RUN cycle

    a_if.start = 1'b0; a_if.mode = 2'd0; a_if.abort = 1'b0;
    b_if.start = 1'b0; b_if.mode = 2'd0; b_if.abort = 1'b0;
    c_if.start = 1'b0; c_if.mode = 2'd0; c_if.abort = 1'b0;

    #12 rst_n = 1'b1;
    step();
    chk("rst_x", int'(a_if.x), 0);
    chk("rst_idx", int'(a_if.vec_idx), 0);
    chk("rst_busy", int'(a_if.busy), 0);
    chk("rst_done", int'(a_if.done), 0);
    chk("rst_ones", int'(a_if.ones_cnt), 0);
    chk("rst_map", int'(a_if.resp_map), 0);

    // Abort while idle is ignored.
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;
    chk("idle_abort_busy", int'(a_if.busy), 0);

    // Directed table, back to back.
    foreach (tbl[i])
      run_a(tbl[i].mode, tbl[i].yt, tbl[i].abort_vec, tbl[i].abort_off,
            tbl[i].exp_map, tbl[i].exp_ones);

    // Randomized sweeps against the model.
    for (int r = 0; r < 25; r++) begin
      m  = int'($urandom_range(0, 3));
      yt = 8'($urandom);
      n  = (m == 2) ? 3 : 8;
      av = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      ao = int'($urandom_range(0, 1));
      samples = (av >= 0) ? av : n;
      model(m, yt, samples, em, eo);
      run_a(m, yt, av, ao, em, eo);
    end

    // Mid-sweep start ignored, then unaligned reset clears everything at once.
    ytab_a = 8'hFF;
    a_if.start = 1'b1;
    a_if.mode  = 2'd0;
    step();
    a_if.start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    a_if.start = 1'b1;
    a_if.mode  = 2'd3;
    step();
    a_if.start = 1'b0;
    chk("run_start_ignored_x", int'(a_if.x), 2);
    chk("mid_ones", int'(a_if.ones_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_x", int'(a_if.x), 0);
    chk("async_idx", int'(a_if.vec_idx), 0);
    chk("async_busy", int'(a_if.busy), 0);
    chk("async_ones", int'(a_if.ones_cnt), 0);
    chk("async_map", int'(a_if.resp_map), 0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_busy", int'(a_if.busy), 0);
    run_a(1, 8'hFF, -1, 0, 8'hFF, 8);

    // W=4, H=1, walking-one with y=1.
    b_if.start = 1'b1;
    b_if.mode  = 2'd2;
    step();
    b_if.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("b_x", int'(b_if.x), 1 << k);
      chk("b_done_early", int'(b_if.done), 0);
      step();
    end
    chk("b_done", int'(b_if.done), 1);
    chk("b_ones", int'(b_if.ones_cnt), 4);
    chk("b_map", int'(b_if.resp_map), 16'h0116);

    // W=3, H=20, binary up with parity response: done 160 edges after accept.
    c_if.start = 1'b1;
    c_if.mode  = 2'd0;
    step();
    c_if.start = 1'b0;
    cnt = 0;
    while (!c_if.done && cnt < 400) begin
      step();
      cnt++;
    end
    chk("c_latency", cnt, 160);
    chk("c_map", int'(c_if.resp_map), 8'h96);
    chk("c_ones", int'(c_if.ones_cnt), 4);
    chk("c_x_final", int'(c_if.x), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
